// File: rtl/ca3_pkg.sv
// ca3_pkg: shared helpers for the CA3 AND-tree blocks.
//   clog3(n)          - ceil(log3(n)); tree depth needed to reduce n terms to 1
//   level_count(n, k) - number of terms left after k three-input AND levels
//   AND_PAD           - identity value used to pad partial groups of three
package ca3_pkg;

    localparam logic AND_PAD = 1'b1;

    function automatic int clog3(input int n);
        int lvl;
        int span;
        lvl  = 0;
        span = 1;
        while (span < n) begin
            span = span * 3;
            lvl++;
        end
        return lvl;
    endfunction

    function automatic int level_count(input int n, input int k);
        int cnt;
        cnt = n;
        for (int i = 0; i < k; i++) begin
            cnt = (cnt + 2) / 3;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/CA3_and_3.sv
// CA3_and_3: three-input AND cell, the basic node of the CA3 AND trees.
//   a_i, b_i, c_i - inputs
//   y_o           - a_i & b_i & c_i
module CA3_and_3 (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic y_o
);

    assign y_o = a_i & b_i & c_i;

endmodule

// File: rtl/ca3_and_level.sv
// ca3_and_level: one combinational level of the AND tree for WIDTH lanes.
// Each lane's IN_CNT terms are grouped in threes in index order; a partial
// last group is padded with AND_PAD so it does not affect the result.
//   data_i - lane l terms at [l*IN_CNT +: IN_CNT]
//   data_o - lane l terms at [l*OUT_CNT +: OUT_CNT], OUT_CNT = ceil(IN_CNT/3)
module ca3_and_level
    import ca3_pkg::*;
#(
    parameter int IN_CNT = 9,
    parameter int WIDTH  = 8
) (
    input  logic [WIDTH*IN_CNT-1:0]           data_i,
    output logic [WIDTH*((IN_CNT+2)/3)-1:0]   data_o
);

    localparam int OUT_CNT = (IN_CNT + 2) / 3;
    localparam int PAD_CNT = 3 * OUT_CNT;

    for (genvar l = 0; l < WIDTH; l++) begin : g_lane
        logic [PAD_CNT-1:0] padded;

        always_comb begin
            padded              = {PAD_CNT{AND_PAD}};
            padded[IN_CNT-1:0]  = data_i[l*IN_CNT +: IN_CNT];
        end

        for (genvar g = 0; g < OUT_CNT; g++) begin : g_node
            CA3_and_3 u_and (
                .a_i (padded[3*g]),
                .b_i (padded[3*g+1]),
                .c_i (padded[3*g+2]),
                .y_o (data_o[l*OUT_CNT+g])
            );
        end
    end

endmodule

// File: rtl/ca3_and_tree_pipe.sv
// ca3_and_tree_pipe: pipelined N_IN-input AND/NAND reduction over WIDTH lanes.
// One register bank per tree level; all banks advance together on en.
//   clk, rst           - clock, asynchronous active-high reset
//   flush              - synchronous clear of every in-flight transaction
//   in_valid/in_ready  - input handshake (in_ready = en, never from in_valid)
//   in_data            - lane l at [l*N_IN +: N_IN]
//   in_invert          - 1 = NAND result for this transaction
//   out_valid/out_ready- output handshake
//   out_data           - bit l = AND (or NAND) of lane l
module ca3_and_tree_pipe
    import ca3_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_IN  = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH*N_IN-1:0] in_data,
    input  logic                  in_invert,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data
);

    localparam int LEVELS = clog3(N_IN);

    logic en;

    // Whole pipe moves as one; bubbles are carried, not collapsed.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < LEVELS; k++) begin : g_stage
        localparam int CNT_IN  = level_count(N_IN, k);
        localparam int CNT_OUT = level_count(N_IN, k + 1);

        logic [WIDTH*CNT_IN-1:0]  lvl_in;
        logic [WIDTH*CNT_OUT-1:0] lvl_out;
        logic [WIDTH*CNT_OUT-1:0] data_d, data_q;
        logic                     vld_in, inv_in;
        logic                     vld_d, vld_q;
        logic                     inv_d, inv_q;

        if (k == 0) begin : g_src
            assign lvl_in = in_data;
            assign vld_in = in_valid;
            assign inv_in = in_invert;
        end else begin : g_src
            assign lvl_in = g_stage[k-1].data_q;
            assign vld_in = g_stage[k-1].vld_q;
            assign inv_in = g_stage[k-1].inv_q;
        end

        ca3_and_level #(
            .IN_CNT (CNT_IN),
            .WIDTH  (WIDTH)
        ) u_level (
            .data_i (lvl_in),
            .data_o (lvl_out)
        );

        // Flush wins over an accept. Bubbles carry zeroed data and invert so
        // an empty output slot always reads as 0.
        always_comb begin
            vld_d  = vld_q;
            inv_d  = inv_q;
            data_d = data_q;
            if (flush) begin
                vld_d  = 1'b0;
                inv_d  = 1'b0;
                data_d = '0;
            end else if (en) begin
                vld_d  = vld_in;
                inv_d  = vld_in ? inv_in : 1'b0;
                data_d = vld_in ? lvl_out : '0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q  <= 1'b0;
                inv_q  <= 1'b0;
                data_q <= '0;
            end else begin
                vld_q  <= vld_d;
                inv_q  <= inv_d;
                data_q <= data_d;
            end
        end
    end

    assign out_valid = g_stage[LEVELS-1].vld_q;
    assign out_data  = g_stage[LEVELS-1].data_q ^ {WIDTH{g_stage[LEVELS-1].inv_q}};

endmodule

// File: tb/tb_ca3_and_tree_pipe.sv
module tb_ca3_and_tree_pipe;

    localparam int W = 8;
    localparam int N = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic           rst, flush, in_valid, in_ready, in_invert, out_valid, out_ready;
    logic [W*N-1:0] in_data;
    logic [W-1:0]   out_data;

    // WIDTH=1, N_IN=2 instance
    logic           rst_b, flush_b, in_valid_b, in_ready_b, in_invert_b, out_valid_b, out_ready_b;
    logic [1:0]     in_data_b;
    logic [0:0]     out_data_b;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    ca3_and_tree_pipe #(.WIDTH(W), .N_IN(N)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_invert(in_invert),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    ca3_and_tree_pipe #(.WIDTH(1), .N_IN(2)) dut_b (
        .clk(clk), .rst(rst_b), .flush(flush_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .in_invert(in_invert_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b)
    );

    // Reference: each lane is the AND of all its N bits, optionally inverted.
    function automatic logic [W-1:0] model(input logic [W*N-1:0] d, input logic inv);
        logic [W-1:0] r;
        for (int l = 0; l < W; l++) begin
            r[l] = &d[l*N +: N];
        end
        return r ^ {W{inv}};
    endfunction

    // Random lane data biased toward all-ones so AND results vary.
    function automatic logic [W*N-1:0] gen_data();
        logic [W*N-1:0] d;
        d = '1;
        for (int l = 0; l < W; l++) begin
            if ($urandom_range(0, 1) == 1) begin
                d[l*N + $urandom_range(0, N-1)] = 1'b0;
                if ($urandom_range(0, 3) == 0) d[l*N + $urandom_range(0, N-1)] = 1'b0;
            end
        end
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; rst_b = 1'b1;
        flush = 1'b0; in_valid = 1'b0; in_data = '0; in_invert = 1'b0; out_ready = 1'b1;
        flush_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0; in_invert_b = 1'b0; out_ready_b = 1'b1;
        tick(); tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        rst = 1'b0; rst_b = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            errors++; $display("FAIL post_reset_idle: got v=%b d=%h want v=0 d=00", out_valid, out_data);
        end
    endtask

    task automatic test_all_ones();
        in_valid = 1'b1; in_data = '1; in_invert = 1'b0; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_data = '0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL ones_latency1: got out_valid=%b want 0", out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL ones_latency2: got out_valid=%b want 1", out_valid); end
        checks++;
        if (out_data !== 8'hFF) begin errors++; $display("FAIL ones_data: got %h want ff", out_data); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL ones_drain: got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_nand_lane3();
        logic [W*N-1:0] d;
        d = '1;
        d[3*N + 4] = 1'b0;
        in_valid = 1'b1; in_data = d; in_invert = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_data = '0; in_invert = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h08) begin
            errors++; $display("FAIL nand_lane3: got v=%b d=%h want v=1 d=08", out_valid, out_data);
        end
        checks++;
        if (out_data !== model(d, 1'b1)) begin
            errors++; $display("FAIL nand_lane3_model: got %h want %h", out_data, model(d, 1'b1));
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] lane0 [4];
        logic [W-1:0] expv  [4];
        logic [W*N-1:0] d;
        lane0[0] = 9'h1FF; lane0[1] = 9'h1FE; lane0[2] = 9'h1FF; lane0[3] = 9'h0FF;
        expv[0] = 8'hFF; expv[1] = 8'hFE; expv[2] = 8'hFF; expv[3] = 8'hFE;
        out_ready = 1'b1; in_invert = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc < 4) begin
                d = '1;
                d[N-1:0] = lane0[cyc];
                in_valid = 1'b1; in_data = d;
            end else begin
                in_valid = 1'b0; in_data = '0;
            end
            tick();
            if (cyc >= 1 && cyc <= 4) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== expv[cyc-1]) begin
                    errors++;
                    $display("FAIL b2b_item%0d: got v=%b d=%h want v=1 d=%h", cyc-1, out_valid, out_data, expv[cyc-1]);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_stall();
        logic [W*N-1:0] da, db, dc;
        logic           ia, ib, ic;
        da = gen_data(); db = gen_data(); dc = gen_data();
        ia = 1'($urandom_range(0, 1)); ib = 1'($urandom_range(0, 1)); ic = 1'($urandom_range(0, 1));
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = da; in_invert = ia;
        tick();
        in_data = db; in_invert = ib;
        tick();
        // A at output, B in first stage; now stall with C pending.
        out_ready = 1'b0;
        in_data = dc; in_invert = ic;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready%0d: got %b want 0", i, in_ready); end
            checks++;
            if (out_valid !== 1'b1 || out_data !== model(da, ia)) begin
                errors++; $display("FAIL stall_hold%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, model(da, ia));
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0; in_data = '0; in_invert = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== model(db, ib)) begin
            errors++; $display("FAIL stall_release_b: got v=%b d=%h want v=1 d=%h", out_valid, out_data, model(db, ib));
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== model(dc, ic)) begin
            errors++; $display("FAIL stall_release_c: got v=%b d=%h want v=1 d=%h", out_valid, out_data, model(dc, ic));
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_no_dup: got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_flush();
        logic [W*N-1:0] dw;
        out_ready = 1'b1; in_invert = 1'b0;
        in_valid = 1'b1; in_data = gen_data();
        tick();
        in_data = gen_data();
        tick();
        // Two in flight; flush together with a new in_valid.
        flush = 1'b1; in_data = '1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0; in_data = '0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_quiet%0d: got out_valid=%b want 0", i, out_valid); end
            tick();
        end
        dw = gen_data();
        in_valid = 1'b1; in_data = dw; in_invert = 1'b1;
        tick();
        in_valid = 1'b0; in_data = '0; in_invert = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== model(dw, 1'b1)) begin
            errors++; $display("FAIL flush_after: got v=%b d=%h want v=1 d=%h", out_valid, out_data, model(dw, 1'b1));
        end
        idle(2);
    endtask

    task automatic test_random();
        logic [W-1:0] e;
        exp_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = gen_data();
            in_invert = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, in_ready, (!out_valid || out_ready));
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_spurious c%0d: got d=%h want no output", cyc, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        errors++; $display("FAIL rnd_data c%0d: got %h want %h", cyc, out_data, e);
                    end
                end
            end
            if (in_valid && in_ready === 1'b1) exp_q.push_back(model(in_data, in_invert));
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_drain_spurious: got d=%h want no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        errors++; $display("FAIL rnd_drain_data: got %h want %h", out_data, e);
                    end
                end
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rnd_lost: got %0d outstanding want 0", exp_q.size());
        end
    endtask

    task automatic test_small_async_reset();
        out_ready_b = 1'b1;
        in_valid_b = 1'b1; in_data_b = 2'b11; in_invert_b = 1'b0;
        tick();
        checks++;
        if (out_valid_b !== 1'b1 || out_data_b !== 1'b1) begin
            errors++; $display("FAIL small_11: got v=%b d=%b want v=1 d=1", out_valid_b, out_data_b);
        end
        in_data_b = 2'b01;
        tick();
        checks++;
        if (out_valid_b !== 1'b1 || out_data_b !== 1'b0) begin
            errors++; $display("FAIL small_01: got v=%b d=%b want v=1 d=0", out_valid_b, out_data_b);
        end
        in_data_b = 2'b11; in_invert_b = 1'b0;
        tick();
        in_valid_b = 1'b0;
        checks++;
        if (out_valid_b !== 1'b1 || out_data_b !== 1'b1) begin
            errors++; $display("FAIL small_pre_rst: got v=%b d=%b want v=1 d=1", out_valid_b, out_data_b);
        end
        #2;
        rst_b = 1'b1;
        #1;
        checks++;
        if (out_valid_b !== 1'b0 || out_data_b !== 1'b0) begin
            errors++; $display("FAIL small_async_rst: got v=%b d=%b want v=0 d=0", out_valid_b, out_data_b);
        end
        #1;
        rst_b = 1'b0;
        tick();
        checks++;
        if (out_valid_b !== 1'b0) begin errors++; $display("FAIL small_after_rst: got v=%b want 0", out_valid_b); end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_nand_lane3();
        test_back_to_back();
        idle(2);
        test_stall();
        idle(2);
        test_flush();
        test_random();
        test_small_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
